hazard_scoreboard: RTL and testbench

- Parametrised, scoreboard-based successor to the pipeline's load-use/branch hazard detector.
- Keeps one countdown counter per architectural register. Each counter holds the cycles left before a pending result can be forwarded to a decode-stage consumer.
- Supports variable-latency producers (ALU, load, multi-cycle multiply) and branch operands resolved in ID.
- Drives PCWrite/IFIDWrite/ControlWrite between IF/ID and ID/EX, plus a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/sb_reg_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: producer latency encodings,
// the default branch penalty and the counter width derivation.
package hazard_scoreboard_pkg;

    localparam int LAT_ALU      = 0;
    localparam int LAT_LOAD     = 1;
    localparam int LAT_MUL      = 4;
    localparam int BR_EXTRA_DEF = 1;

    // Counter must hold the largest load value, MAX_LAT + BR_EXTRA.
    function automatic int cnt_width(input int max_lat, input int br_extra);
        return $clog2(max_lat + br_extra + 1);
    endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Countdown for one architectural register: saturating decrement, max-merge
// on load so a longer pending latency survives a later shorter writer.
module sb_reg_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec;

    always_comb begin
        dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        cnt_d = dec;
        if (clr)
            cnt_d = '0;
        else if (load_en && (load_val > dec))
            cnt_d = load_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard detector: per-register countdowns decide whether the ID
// instruction must stall; also counts stall cycles (saturating).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 5,
    parameter int MAX_LAT     = 6,
    parameter int LAT_W       = 3,
    parameter int BR_EXTRA    = BR_EXTRA_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   IFIDValid,
    input  logic [REG_W-1:0]       IFIDRs,
    input  logic [REG_W-1:0]       IFIDRt,
    input  logic                   IFIDRsUse,
    input  logic                   IFIDRtUse,
    input  logic                   IFIDBranch,
    input  logic                   IFIDRegWrite,
    input  logic [REG_W-1:0]       IFIDRd,
    input  logic [LAT_W-1:0]       IFIDLat,
    input  logic                   Flush,
    input  logic                   SbClear,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   ControlWrite,
    output logic                   Busy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int               CNT_W      = cnt_width(MAX_LAT, BR_EXTRA);
    localparam logic [CNT_W-1:0] BR_EXTRA_C = CNT_W'(BR_EXTRA);
    localparam logic [LAT_W-1:0] MAX_LAT_L  = LAT_W'(MAX_LAT);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]               rs_cnt, rt_cnt, thresh, load_val;
    logic [LAT_W-1:0]               lat_eff;
    logic                           rs_haz, rt_haz, stall, issue;
    logic [STALL_CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

    // r0 is hard-wired, so its slot is a constant zero.
    assign cnt[0] = '0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk      (Clk),
                .rst      (Reset),
                .clr      (SbClear),
                .load_en  (issue && (IFIDRd == REG_W'(r))),
                .load_val (load_val),
                .cnt      (cnt[r])
            );
        end
    endgenerate

    // Branches compare in ID and so need the result BR_EXTRA cycles earlier.
    always_comb begin
        rs_cnt   = cnt[IFIDRs];
        rt_cnt   = cnt[IFIDRt];
        thresh   = IFIDBranch ? '0 : BR_EXTRA_C;
        rs_haz   = IFIDRsUse && (IFIDRs != '0) && (rs_cnt > thresh);
        rt_haz   = IFIDRtUse && (IFIDRt != '0) && (rt_cnt > thresh);
        stall    = IFIDValid && !Flush && (rs_haz || rt_haz);
        issue    = IFIDValid && !stall && !Flush && IFIDRegWrite && (IFIDRd != '0);
        lat_eff  = (IFIDLat > MAX_LAT_L) ? MAX_LAT_L : IFIDLat;
        load_val = CNT_W'(lat_eff) + BR_EXTRA_C;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign PCWrite      = !stall;
    assign IFIDWrite    = !stall;
    assign ControlWrite = !stall;
    assign Busy         = |cnt;
    assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand sequences for
// latency clamp / saturation / async reset, and a randomized model comparison.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int MAX_LAT  = 6;
    localparam int LAT_W    = 3;
    localparam int BR_EXTRA = 1;
    localparam int SC_W     = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             IFIDValid, IFIDRsUse, IFIDRtUse, IFIDBranch, IFIDRegWrite;
    logic [REG_W-1:0] IFIDRs, IFIDRt, IFIDRd;
    logic [LAT_W-1:0] IFIDLat;
    logic             Flush, SbClear;
    logic             PCWrite, IFIDWrite, ControlWrite, Busy;
    logic [SC_W-1:0]  StallCount;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W),
        .BR_EXTRA(BR_EXTRA), .STALL_CNT_W(SC_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .IFIDValid(IFIDValid), .IFIDRs(IFIDRs),
        .IFIDRt(IFIDRt), .IFIDRsUse(IFIDRsUse), .IFIDRtUse(IFIDRtUse),
        .IFIDBranch(IFIDBranch), .IFIDRegWrite(IFIDRegWrite), .IFIDRd(IFIDRd),
        .IFIDLat(IFIDLat), .Flush(Flush), .SbClear(SbClear), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .ControlWrite(ControlWrite), .Busy(Busy),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit       valid, rsu, rtu, br, rw, flush, clr;
        int       rs, rt, rd, lat;
        bit       exp_pcw, exp_busy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[26];
    int   m_cnt[NUM_REGS];
    int   m_sc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit v, int rs, int rt, bit rsu, bit rtu, bit br, bit rw,
                                int rd, int lat, bit fl, bit cl, bit pcw, bit busy);
        vec_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu; t.br = br;
        t.rw = rw; t.rd = rd; t.lat = lat; t.flush = fl; t.clr = cl;
        t.exp_pcw = pcw; t.exp_busy = busy;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        IFIDValid = t.valid; IFIDRs = REG_W'(t.rs); IFIDRt = REG_W'(t.rt);
        IFIDRsUse = t.rsu; IFIDRtUse = t.rtu; IFIDBranch = t.br;
        IFIDRegWrite = t.rw; IFIDRd = REG_W'(t.rd); IFIDLat = LAT_W'(t.lat);
        Flush = t.flush; SbClear = t.clr;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(posedge Clk); #1;
        Reset = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_sc = 0;
    endtask

    // Model: stall decision from the hazard rules applied to plain int counters.
    function automatic bit m_stall(input vec_t t);
        bit h = 0;
        int need = t.br ? 0 : BR_EXTRA;
        if (t.rsu && t.rs != 0 && m_cnt[t.rs] > need) h = 1;
        if (t.rtu && t.rt != 0 && m_cnt[t.rt] > need) h = 1;
        return t.valid && !t.flush && h;
    endfunction

    task automatic m_update(input vec_t t, input bit st);
        int lat = (t.lat > MAX_LAT) ? MAX_LAT : t.lat;
        int old_rd = m_cnt[t.rd];
        foreach (m_cnt[i]) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (t.clr)
            foreach (m_cnt[i]) m_cnt[i] = 0;
        else if (t.valid && !st && !t.flush && t.rw && t.rd != 0)
            m_cnt[t.rd] = (old_rd - 1 > lat + BR_EXTRA) ? old_rd - 1 : lat + BR_EXTRA;
        if (st && m_sc < 65535) m_sc++;
    endtask

    initial begin
        int exp_sc;
        int stalls;
        bit m_any;
        vec_t r;

        // ---- reset state ----
        Reset = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        #1;
        chk("reset_pcw", {31'd0, PCWrite}, 1);
        chk("reset_busy", {31'd0, Busy}, 0);
        chk("reset_sc", {16'd0, StallCount}, 0);
        do_reset();

        // ---- directed table ----
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1, 0);   // lw r8
        tbl[1]  = mk(1, 8, 0, 1, 0, 0, 1, 12, 0, 0, 0, 0, 1);  // add uses r8: stall
        tbl[2]  = mk(1, 8, 0, 1, 0, 0, 1, 12, 0, 0, 0, 1, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 1);   // alu r9
        tbl[4]  = mk(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);   // beq r9: 1 stall
        tbl[5]  = mk(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 1, 0);   // lw r9
        tbl[7]  = mk(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);   // beq r9: 2 stalls
        tbl[8]  = mk(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 10, 4, 0, 0, 1, 0);  // mul r10
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1, 1);  // lw r10 (WAW)
        tbl[12] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // add r10: 3 stalls
        tbl[13] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1, 0);   // write r0
        tbl[17] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);   // read r0
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 11, 2, 0, 0, 1, 0);  // r11 cnt 3
        tbl[19] = mk(1, 11, 0, 1, 0, 0, 1, 13, 3, 1, 0, 1, 1); // flush wins
        tbl[20] = mk(1, 11, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);  // clear, still stalls
        tbl[21] = mk(1, 11, 13, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 1, 14, 3, 0, 1, 1, 0);  // clear beats issue
        tbl[23] = mk(1, 14, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 1, 16, 4, 0, 0, 1, 0);  // not valid
        tbl[25] = mk(1, 16, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        exp_sc = 0;
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i]);
            @(negedge Clk);
            chk($sformatf("tbl%0d_pcw", i), {31'd0, PCWrite}, {31'd0, tbl[i].exp_pcw});
            chk($sformatf("tbl%0d_ifidw", i), {31'd0, IFIDWrite}, {31'd0, tbl[i].exp_pcw});
            chk($sformatf("tbl%0d_ctlw", i), {31'd0, ControlWrite}, {31'd0, tbl[i].exp_pcw});
            chk($sformatf("tbl%0d_busy", i), {31'd0, Busy}, {31'd0, tbl[i].exp_busy});
            chk($sformatf("tbl%0d_sc", i), {16'd0, StallCount}, exp_sc);
            if (!tbl[i].exp_pcw) exp_sc++;
            @(posedge Clk); #1;
        end

        // ---- latency above MAX_LAT clamps to MAX_LAT: branch sees 7 stalls ----
        drive(mk(1, 0, 0, 0, 0, 0, 1, 15, 7, 0, 0, 1, 0));
        @(posedge Clk); #1;
        drive(mk(1, 15, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (PCWrite) break;
            stalls++;
            @(posedge Clk); #1;
        end
        chk("lat_clamp_stalls", stalls, MAX_LAT + BR_EXTRA);

        // ---- randomized comparison against the model ----
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit st;
            r.valid = ($urandom_range(0, 9) != 0);
            r.rs = $urandom_range(0, 7); r.rt = $urandom_range(0, 7);
            r.rsu = $urandom_range(0, 1); r.rtu = $urandom_range(0, 1);
            r.br = ($urandom_range(0, 3) == 0);
            r.rw = $urandom_range(0, 1);
            r.rd = $urandom_range(0, 7);
            r.lat = $urandom_range(0, 7);
            r.flush = ($urandom_range(0, 9) == 0);
            r.clr = ($urandom_range(0, 19) == 0);
            drive(r);
            @(negedge Clk);
            st = m_stall(r);
            m_any = 0;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) m_any = 1;
            chk("rnd_pcw", {31'd0, PCWrite}, {31'd0, !st});
            chk("rnd_ctlw", {31'd0, ControlWrite}, {31'd0, !st});
            chk("rnd_busy", {31'd0, Busy}, {31'd0, m_any});
            chk("rnd_sc", {16'd0, StallCount}, m_sc);
            m_update(r, st);
            @(posedge Clk); #1;
        end

        // ---- StallCount saturation: self-dependent branch stalls 7 of 8 cycles ----
        drive(mk(1, 5, 0, 1, 0, 1, 1, 5, 6, 0, 0, 1, 0));
        repeat (75000) @(posedge Clk);
        #1;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (!PCWrite) begin stalls = 1; break; end
        end
        chk("sat_found_stall", stalls, 1);
        chk("sat_sc", {16'd0, StallCount}, 32'h0000_FFFF);

        // ---- async reset mid-stall releases outputs before the next edge ----
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_pcw", {31'd0, PCWrite}, 1);
        chk("async_rst_ifidw", {31'd0, IFIDWrite}, 1);
        chk("async_rst_sc", {16'd0, StallCount}, 0);
        chk("async_rst_busy", {31'd0, Busy}, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
